advance_sequencer: RTL

ADVANCE_SEQUENCER -- requirements
Module: advance_sequencer

---
 rtl/advance_sequencer_pkg.sv | 11 +
 rtl/advance_sequencer_dwell_timer.sv | 33 +++
 rtl/advance_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/advance_sequencer_pkg.sv
// Shared types and constants for the advance sequencer and its dwell timer.
package advance_sequencer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } seq_state_e;

  localparam int unsigned MIN_DWELL = 1;

endpackage

// File: rtl/advance_sequencer_dwell_timer.sv
// Dwell down-counter: loads the step length, decrements while dwelling,
// and flags the last active cycle with a terminal-count compare.
module dwell_timer
  import advance_sequencer_pkg::*;
#(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_value,
  input  logic               decrement,
  input  logic               clear,
  output logic [DWELL_W-1:0] count,
  output logic               terminal
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement && (count != '0)) begin
      count <= count - DWELL_W'(1);
    end
  end

  // Count reaches MIN_DWELL on the final active cycle of a step.
  assign terminal = (count == DWELL_W'(MIN_DWELL));

endmodule

// File: rtl/advance_sequencer.sv
// Advance sequencer: steps an index on accepted advance pulses, holding each
// step active for a programmable dwell, with frame wrap and sticky overrun.
//
//   state | meaning
//   IDLE  | waiting for an advance with enable high
//   DWELL | step in progress, active/busy high until the timer terminates
module advance_sequencer
  import advance_sequencer_pkg::*;
#(
  parameter int unsigned STEPS   = 8,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               advance,
  input  logic               enable,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [IDX_W-1:0]   last_step,
  input  logic               clear_overrun,
  output logic [IDX_W-1:0]   index,
  output logic               active,
  output logic               step_done,
  output logic               frame_done,
  output logic               busy,
  output logic               overrun
);

  localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(STEPS - 1);

  seq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   index_d;
  logic               step_done_d, frame_done_d, overrun_d;
  logic               tmr_load, tmr_dec, tmr_clear, tmr_terminal;
  logic [DWELL_W-1:0] tmr_count;
  logic [DWELL_W-1:0] dwell_eff;
  logic [IDX_W-1:0]   last_clamped;
  logic               wrap;

  assign dwell_eff    = (dwell == '0) ? DWELL_W'(MIN_DWELL) : dwell;
  assign last_clamped = (last_step > LAST_MAX) ? LAST_MAX : last_step;
  // >= rather than == so a stale index beyond the frame still wraps.
  assign wrap         = (index >= last_q);

  dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_dwell_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (dwell_eff),
    .decrement  (tmr_dec),
    .clear      (tmr_clear),
    .count      (tmr_count),
    .terminal   (tmr_terminal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= '0;
      index      <= '0;
      step_done  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      index      <= index_d;
      step_done  <= step_done_d;
      frame_done <= frame_done_d;
      overrun    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    index_d      = index;
    step_done_d  = 1'b0;
    frame_done_d = 1'b0;
    overrun_d    = overrun;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    tmr_clear    = 1'b0;

    if (clear_overrun) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (advance && enable) begin
          state_d  = DWELL;
          tmr_load = 1'b1;
          last_d   = last_clamped;
        end
      end
      DWELL: begin
        // Set after clear so a coincident drop keeps the flag.
        if (advance) begin
          overrun_d = 1'b1;
        end
        if (!enable) begin
          state_d   = IDLE;
          tmr_clear = 1'b1;
        end else if (tmr_terminal) begin
          state_d      = IDLE;
          tmr_dec      = 1'b1;
          step_done_d  = 1'b1;
          frame_done_d = wrap;
          index_d      = wrap ? '0 : index + IDX_W'(1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        tmr_clear = 1'b1;
      end
    endcase
  end

  assign active = (state_q == DWELL);
  assign busy   = (state_q == DWELL);

endmodule
